// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD/FCS, forwards payload bytes,
// checks CRC-32, length and GMII errors, and reports per-frame status and counts.
module gmii_rx_frame_parser #(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic        rx_clk,
   input  logic        rst,
   input  logic        rx_dv_gm,
   input  logic        rx_er_gm,
   input  logic [7:0]  rxd_gm,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        rx_sop,
   output logic        rx_done,
   output logic [3:0]  rx_err,
   output logic [15:0] frame_len,
   output logic [31:0] good_cnt,
   output logic [31:0] bad_cnt
);

   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t      state, state_next;
   logic [2:0]  pre_cnt;
   logic        drop_report;

   logic        start_frame, take_byte, end_frame, pre_fail, arm_drop;

   logic [31:0] crc;
   logic [15:0] len_cnt;
   logic        gm_err;
   logic [7:0]  dly [4];
   logic [2:0]  fill;
   logic        sop_pend;

   logic        len_bad, crc_bad;
   logic [3:0]  frame_err;

   // Reflected CRC-32, one byte LSB first.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      // NOTE: blocking assignments are correct here; this is a combinational
      // function evaluated bit by bit, not clocked state.
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ CRC_POLY;
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can infer a latch.
      state_next  = state;
      start_frame = 1'b0;
      take_byte   = 1'b0;
      end_frame   = 1'b0;
      pre_fail    = 1'b0;
      arm_drop    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_dv_gm) begin
               if (rxd_gm == PRE_BYTE) begin
                  state_next = PREAMBLE;
               end else if (rxd_gm == SFD_BYTE) begin
                  state_next  = DATA;
                  start_frame = 1'b1;
               end else begin
                  state_next = DROP;
                  arm_drop   = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (!rx_dv_gm) begin
               state_next = IDLE;
               pre_fail   = 1'b1;
            end else if (rxd_gm == SFD_BYTE) begin
               state_next  = DATA;
               start_frame = 1'b1;
            end else if (rxd_gm != PRE_BYTE || pre_cnt == 3'd7) begin
               state_next = DROP;
               arm_drop   = 1'b1;
            end
         end
         DATA: begin
            if (rx_dv_gm) begin
               take_byte = 1'b1;
            end else begin
               state_next = IDLE;
               end_frame  = 1'b1;
            end
         end
         DROP: begin
            if (!rx_dv_gm) begin
               state_next = IDLE;
               pre_fail   = drop_report;
            end
         end
         default: state_next = DROP;
      endcase
   end

   // Reset parks in DROP with reporting disarmed so a frame in flight is discarded silently.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state       <= DROP;
         pre_cnt     <= 3'd0;
         drop_report <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == PREAMBLE)
            pre_cnt <= (state == PREAMBLE) ? pre_cnt + 3'd1 : 3'd1;
         else
            pre_cnt <= 3'd0;
         if (arm_drop) drop_report <= 1'b1;
      end
   end

   assign len_bad   = (32'(len_cnt) < MIN_LEN) || (32'(len_cnt) > MAX_LEN);
   assign crc_bad   = (crc != CRC_RESIDUE);
   assign frame_err = {1'b0, gm_err, len_bad, crc_bad};

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         rx_valid  <= 1'b0;
         rx_data   <= 8'd0;
         rx_sop    <= 1'b0;
         rx_done   <= 1'b0;
         rx_err    <= 4'd0;
         frame_len <= 16'd0;
         good_cnt  <= 32'd0;
         bad_cnt   <= 32'd0;
         crc       <= 32'd0;
         len_cnt   <= 16'd0;
         gm_err    <= 1'b0;
         fill      <= 3'd0;
         sop_pend  <= 1'b0;
         // NOTE: the delay line is only four bytes of flops, so it is cleared
         // explicitly; a RAM-sized array would be left out of reset.
         for (int i = 0; i < 4; i++) dly[i] <= 8'd0;
      end else begin
         rx_valid <= 1'b0;
         rx_sop   <= 1'b0;
         rx_done  <= 1'b0;

         if (start_frame) begin
            crc      <= CRC_INIT;
            len_cnt  <= 16'd0;
            gm_err   <= 1'b0;
            fill     <= 3'd0;
            sop_pend <= 1'b1;
         end

         if (take_byte) begin
            crc <= crc_step(crc, rxd_gm);
            if (len_cnt != 16'hFFFF) len_cnt <= len_cnt + 16'd1;
            if (rx_er_gm) gm_err <= 1'b1;
            dly[0] <= rxd_gm;
            for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
            // Once four bytes are buffered, the oldest can no longer be FCS.
            if (fill == 3'd4) begin
               rx_valid <= 1'b1;
               rx_data  <= dly[3];
               rx_sop   <= sop_pend;
               sop_pend <= 1'b0;
            end else begin
               fill <= fill + 3'd1;
            end
         end

         if (end_frame) begin
            rx_done   <= 1'b1;
            rx_err    <= frame_err;
            frame_len <= len_cnt;
            if (frame_err == 4'd0) good_cnt <= good_cnt + 32'd1;
            else                   bad_cnt  <= bad_cnt + 32'd1;
         end

         if (pre_fail) begin
            rx_done   <= 1'b1;
            rx_err    <= 4'b1000;
            frame_len <= 16'd0;
            bad_cnt   <= bad_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed bench for gmii_rx_frame_parser: builds GMII frames with computed FCS
// and checks forwarded payload, status strobes and frame counters.
module tb_gmii_rx_frame_parser;

   typedef logic [7:0] bq_t[$];

   logic        rx_clk = 1'b0;
   logic        rst;
   logic        rx_dv_gm;
   logic        rx_er_gm;
   logic [7:0]  rxd_gm;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_sop;
   logic        rx_done;
   logic [3:0]  rx_err;
   logic [15:0] frame_len;
   logic [31:0] good_cnt;
   logic [31:0] bad_cnt;

   int tests = 0;
   int fails = 0;

   bq_t got;
   int  sop_q[$];
   logic [3:0]  err_q[$];
   logic [15:0] len_q[$];

   gmii_rx_frame_parser #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
      .rx_clk    (rx_clk),
      .rst       (rst),
      .rx_dv_gm  (rx_dv_gm),
      .rx_er_gm  (rx_er_gm),
      .rxd_gm    (rxd_gm),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_sop    (rx_sop),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .frame_len (frame_len),
      .good_cnt  (good_cnt),
      .bad_cnt   (bad_cnt)
   );

   always #5 rx_clk = ~rx_clk;

   // Output monitor, sampled on the falling edge.
   always @(negedge rx_clk) begin
      if (rx_sop) sop_q.push_back(rx_valid ? got.size() : -1);
      if (rx_valid) got.push_back(rx_data);
      if (rx_done) begin
         err_q.push_back(rx_err);
         len_q.push_back(frame_len);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Standard Ethernet FCS value (inverted CRC-32) of a byte sequence.
   function automatic logic [31:0] fcs_of(input bq_t d);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (d[k]) begin
         c = c ^ {24'd0, d[k]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build_frame(input int npay, input int npre, input int seed,
                              output bq_t frm, output bq_t pl);
      logic [31:0] f;
      frm = {};
      pl  = {};
      for (int i = 0; i < npre; i++) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 0; i < npay; i++) pl.push_back(8'(i * 37 + seed));
      foreach (pl[i]) frm.push_back(pl[i]);
      f = fcs_of(pl);
      frm.push_back(f[7:0]);
      frm.push_back(f[15:8]);
      frm.push_back(f[23:16]);
      frm.push_back(f[31:24]);
   endtask

   // Drives one frame, then a single idle cycle with junk on rxd_gm.
   task automatic send_bytes(input bq_t q, input int er_idx);
      foreach (q[i]) begin
         @(posedge rx_clk); #1;
         rx_dv_gm = 1'b1;
         rxd_gm   = q[i];
         rx_er_gm = (i == er_idx);
      end
      @(posedge rx_clk); #1;
      rx_dv_gm = 1'b0;
      rx_er_gm = 1'b0;
      rxd_gm   = 8'hD5;
   endtask

   task automatic clear_mon();
      got.delete();
      sop_q.delete();
      err_q.delete();
      len_q.delete();
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge rx_clk); #2;
         if (err_q.size() >= n) break;
      end
   endtask

   task automatic expect_frame(input string tag, input bq_t pl,
                               input logic [3:0] err, input logic [15:0] len);
      int mm = 0;
      wait_done(1, 40);
      check({tag, "_done_n"}, err_q.size(), 1);
      check({tag, "_err"}, (err_q.size() > 0) ? err_q[0] : 4'hF, err);
      check({tag, "_len"}, (len_q.size() > 0) ? len_q[0] : 16'hFFFF, len);
      check({tag, "_nbytes"}, got.size(), pl.size());
      foreach (pl[i]) if (i >= got.size() || got[i] !== pl[i]) mm++;
      check({tag, "_payload"}, mm, 0);
      check({tag, "_sop_n"}, sop_q.size(), (pl.size() > 0) ? 1 : 0);
      if (sop_q.size() > 0) check({tag, "_sop_pos"}, sop_q[0], 0);
      clear_mon();
   endtask

   initial begin
      bq_t frm, pl, frm2, pl2;
      int  mm;

      rst      = 1'b1;
      rx_dv_gm = 1'b0;
      rx_er_gm = 1'b0;
      rxd_gm   = 8'h00;
      repeat (3) @(posedge rx_clk);
      #2;
      check("rst_valid", rx_valid, 0);
      check("rst_sop", rx_sop, 0);
      check("rst_done", rx_done, 0);
      check("rst_data", rx_data, 0);
      check("rst_err", rx_err, 0);
      check("rst_len", frame_len, 0);
      check("rst_good", good_cnt, 0);
      check("rst_bad", bad_cnt, 0);
      @(posedge rx_clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge rx_clk);
      #2;
      check("rst_exit_silent", err_q.size(), 0);
      clear_mon();

      // Nominal 64-byte frame.
      build_frame(60, 7, 3, frm, pl);
      send_bytes(frm, -1);
      expect_frame("good64", pl, 4'b0000, 16'd64);
      check("good64_good_cnt", good_cnt, 1);
      check("good64_bad_cnt", bad_cnt, 0);

      // Corrupted FCS bit.
      build_frame(60, 7, 11, frm, pl);
      frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
      send_bytes(frm, -1);
      expect_frame("badfcs", pl, 4'b0001, 16'd64);
      check("badfcs_bad_cnt", bad_cnt, 1);

      // rx_er_gm on payload byte 10 (stream index 7 + 1 + 10).
      build_frame(60, 7, 29, frm, pl);
      send_bytes(frm, 18);
      expect_frame("gmerr", pl, 4'b0100, 16'd64);
      check("gmerr_bad_cnt", bad_cnt, 2);

      // Preamble byte 3 corrupted.
      build_frame(60, 7, 5, frm, pl);
      frm[3] = 8'h5A;
      pl = {};
      send_bytes(frm, -1);
      expect_frame("badpre", pl, 4'b1000, 16'd0);
      check("badpre_bad_cnt", bad_cnt, 3);

      // 40-byte frame then 64-byte frame with one idle cycle between.
      build_frame(36, 7, 41, frm, pl);
      build_frame(60, 7, 77, frm2, pl2);
      send_bytes(frm, -1);
      send_bytes(frm2, -1);
      wait_done(2, 40);
      check("b2b_done_n", err_q.size(), 2);
      check("b2b_err0", (err_q.size() > 0) ? err_q[0] : 4'hF, 4'b0010);
      check("b2b_len0", (len_q.size() > 0) ? len_q[0] : 16'hFFFF, 16'd40);
      check("b2b_err1", (err_q.size() > 1) ? err_q[1] : 4'hF, 4'b0000);
      check("b2b_len1", (len_q.size() > 1) ? len_q[1] : 16'hFFFF, 16'd64);
      check("b2b_nbytes", got.size(), 96);
      mm = 0;
      foreach (pl2[i]) pl.push_back(pl2[i]);
      foreach (pl[i]) if (i >= got.size() || got[i] !== pl[i]) mm++;
      check("b2b_payload", mm, 0);
      check("b2b_sop_n", sop_q.size(), 2);
      if (sop_q.size() > 1) check("b2b_sop_pos1", sop_q[1], 36);
      check("b2b_good_cnt", good_cnt, 2);
      check("b2b_bad_cnt", bad_cnt, 4);
      clear_mon();

      // Eight preamble bytes is one too many.
      build_frame(60, 8, 9, frm, pl);
      pl = {};
      send_bytes(frm, -1);
      expect_frame("longpre", pl, 4'b1000, 16'd0);

      // SFD with no preamble at all is accepted.
      build_frame(60, 0, 13, frm, pl);
      send_bytes(frm, -1);
      expect_frame("nopre", pl, 4'b0000, 16'd64);
      check("nopre_good_cnt", good_cnt, 3);

      // Sub-5-byte frame: nothing forwarded, short and bad CRC.
      frm = {8'hD5, 8'h01, 8'h02, 8'h03};
      pl  = {};
      send_bytes(frm, -1);
      expect_frame("tiny", pl, 4'b0011, 16'd3);

      // 63-byte frame: one below minimum.
      build_frame(59, 7, 17, frm, pl);
      send_bytes(frm, -1);
      expect_frame("len63", pl, 4'b0010, 16'd63);

      // 1519-byte frame: one above maximum, still forwarded.
      build_frame(1515, 7, 51, frm, pl);
      send_bytes(frm, -1);
      expect_frame("len1519", pl, 4'b0010, 16'd1519);
      check("len1519_bad_cnt", bad_cnt, 8);
      check("len1519_good_cnt", good_cnt, 3);

      // Reset pulsed mid-payload with rx_dv_gm held high.
      build_frame(60, 7, 23, frm, pl);
      foreach (frm[i]) begin
         @(posedge rx_clk); #1;
         if (i == 22) begin
            check("midrst_valid", rx_valid, 0);
            check("midrst_err", rx_err, 0);
            check("midrst_len", frame_len, 0);
            check("midrst_good", good_cnt, 0);
            check("midrst_bad", bad_cnt, 0);
            clear_mon();
         end
         rx_dv_gm = 1'b1;
         rxd_gm   = frm[i];
         rst      = (i == 20 || i == 21);
      end
      @(posedge rx_clk); #1;
      rx_dv_gm = 1'b0;
      repeat (10) @(posedge rx_clk);
      #2;
      check("midrst_no_done", err_q.size(), 0);
      check("midrst_no_bytes", got.size(), 0);
      check("midrst_cnt", good_cnt + bad_cnt, 0);
      clear_mon();

      build_frame(60, 7, 99, frm, pl);
      send_bytes(frm, -1);
      expect_frame("postrst", pl, 4'b0000, 16'd64);
      check("postrst_good_cnt", good_cnt, 1);
      check("postrst_bad_cnt", bad_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gmii_rx_frame_parser.md
GMII_RX_FRAME_PARSER -- requirements
Module: gmii_rx_frame_parser

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes (SFD excluded, FCS included).
REQ-002 Parameter MAX_LEN, default 1518, maximum legal frame length in bytes (same counting).
REQ-003 rx_clk  input  1  GMII receive clock; single clock domain; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_dv_gm  input  1  GMII receive data valid.
REQ-006 rx_er_gm  input  1  GMII receive error.
REQ-007 rxd_gm  input  8  GMII receive byte.
REQ-008 rx_valid  output  1  rx_data holds a payload byte this cycle.
REQ-009 rx_data  output  8  payload byte; preamble, SFD and FCS stripped.
REQ-010 rx_sop  output  1  high with the first payload byte of a frame.
REQ-011 rx_done  output  1  one-cycle end-of-frame status strobe.
REQ-012 rx_err  output  4  {bad_preamble, gmii_err, len_err, crc_err}; valid when rx_done=1.
REQ-013 frame_len  output  16  byte count after SFD, FCS included; valid when rx_done=1.
REQ-014 good_cnt  output  32  count of frames reported with rx_err=0.
REQ-015 bad_cnt  output  32  count of frames reported with rx_err!=0.

Function
REQ-016 FSM states IDLE, PREAMBLE, DATA, DROP; transitions evaluated on sampled inputs each rx_clk edge.
REQ-017 IDLE: rx_dv_gm=1 with rxd_gm=0x55 -> PREAMBLE; with rxd_gm=0xD5 -> DATA; any other byte -> DROP with bad_preamble set.
REQ-018 PREAMBLE: 0x55 stays; 0xD5 -> DATA; other byte, or more than 7 consecutive 0x55, -> DROP with bad_preamble; rx_dv_gm=0 -> IDLE with rx_done, rx_err=4'b1000, frame_len=0.
REQ-019 DROP: no rx_valid; on rx_dv_gm=0 -> IDLE with rx_done, rx_err=4'b1000, frame_len=0.
REQ-020 DATA: each byte with rx_dv_gm=1 increments frame_len (saturating at 0xFFFF), updates CRC, enters a 4-byte delay line; rx_dv_gm=0 -> IDLE.
REQ-021 Delay line: byte k is driven on rx_data with rx_valid=1 in the cycle after byte k+4 is sampled; the last 4 bytes (FCS) are never output; frames under 5 bytes output nothing.
REQ-022 rx_sop=1 only with the first rx_valid of a frame.
REQ-023 CRC-32: reflected polynomial 0xEDB88320, LSB-first, register initialised to 0xFFFFFFFF at SFD; computed over all bytes after SFD, FCS included; crc_err=1 unless the final register equals 0xDEBB20E3.
REQ-024 gmii_err=1 if rx_er_gm=1 on any DATA cycle with rx_dv_gm=1; payload bytes are still forwarded.
REQ-025 len_err=1 if frame_len < MIN_LEN or > MAX_LEN; bytes beyond MAX_LEN are still forwarded.
REQ-026 rx_done is asserted in the cycle after the first cycle sampling rx_dv_gm=0 in DATA; rx_err and frame_len are held until the next rx_done.
REQ-027 good_cnt or bad_cnt increments by 1 on the same edge that asserts rx_done; both wrap modulo 2^32.
REQ-028 Back-to-back frames separated by a single rx_dv_gm=0 cycle are each parsed and reported; the delay line is cleared at every SFD.
REQ-029 rxd_gm is ignored while rx_dv_gm=0.

Reset
REQ-030 While rst=1: rx_valid, rx_sop, rx_done=0; rx_data, rx_err, frame_len=0; good_cnt, bad_cnt=0; delay line and CRC cleared.
REQ-031 The reset state is DROP with reporting suppressed; it exits to IDLE on the first rx_dv_gm=0 sample without asserting rx_done, so a frame in flight at reset release is discarded silently.

Verification
REQ-032 Frame: 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 60 rx_valid bytes matching the payload, rx_sop on byte 0, rx_done with rx_err=0 and frame_len=64, good_cnt=1.
REQ-033 Same frame with one FCS bit flipped -> 60 bytes forwarded, rx_err=4'b0001, bad_cnt=1.
REQ-034 Same frame with rx_er_gm=1 on payload byte 10 -> rx_err=4'b0100, frame_len=64.
REQ-035 Preamble byte 3 = 0x5A -> no rx_valid, rx_done with rx_err=4'b1000 and frame_len=0.
REQ-036 Good-CRC 40-byte frame, then a 64-byte frame after a 1-cycle gap -> first rx_err=4'b0010 with frame_len=40, second rx_err=0; bad_cnt=1 and good_cnt=1.
REQ-037 rst pulsed during payload with rx_dv_gm held high -> outputs zero, no rx_done for that frame, next frame reported good.
